signature_misr_acc: RTL and testbench

- Parametrised sequential successor to the flat combinational test-module outputs.
- Folds an arbitrarily wide DUT output vector (e.g. 1373-bit y) into a SIG_W-bit multiple-input signature register (MISR), one sample per valid cycle, over a programmed number of samples.
- Sits between a generated module under test and the equivalence/simulation checker. The checker compares compact signatures across synthesis tools instead of full-width outputs every cycle.

---
 rtl/signature_misr_acc_pkg.sv | 64 ++++++
 rtl/signature_misr_acc_if.sv | 36 +++
 rtl/signature_misr_acc_fold.sv | 32 +++
 rtl/signature_misr_acc.sv | 107 ++++++++++
 tb/tb_signature_misr_acc.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/signature_misr_acc_pkg.sv
// ---------------------------------------------------------------------------
// misr_pkg
// Shared definitions for the signature MISR accumulator and for anything that
// needs to reproduce its signatures (e.g. the checker's reference model).
//   misr_state_e  : controller states IDLE / RUN / DONE
//   CRC32_POLY    : default feedback polynomial (implicit x^SIG_W term)
//   fold_slices() : XOR-fold of a zero-padded vector into sig_w-bit slices
//   misr_step()   : one MISR shift/feedback/absorb step
// The functions work on fixed maximum-width containers so they can be called
// for any WIDTH <= FOLD_MAX_W and SIG_W <= SIG_MAX_W; unused upper bits are
// expected to be zero on input and are masked on output.
// ---------------------------------------------------------------------------
package misr_pkg;

    localparam int unsigned FOLD_MAX_W = 4096;
    localparam int unsigned SIG_MAX_W  = 64;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_e;

    // Bit i of the input lands in slice bit (i mod sig_w); bits at or above
    // width behave as the zero padding.
    function automatic logic [SIG_MAX_W-1:0] fold_slices(
        input logic [FOLD_MAX_W-1:0] data,
        input int unsigned           width,
        input int unsigned           sig_w
    );
        logic [SIG_MAX_W-1:0] f;
        f = '0;
        if (sig_w != 0) begin
            for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
                if (i < width) begin
                    f[i % sig_w] = f[i % sig_w] ^ data[i];
                end
            end
        end
        return f;
    endfunction

    // Shift left, apply the polynomial when the outgoing MSB was set, absorb
    // the folded sample. Result is masked to sig_w bits.
    function automatic logic [SIG_MAX_W-1:0] misr_step(
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] poly,
        input logic [SIG_MAX_W-1:0] fold,
        input int unsigned          sig_w
    );
        logic [SIG_MAX_W-1:0] mask;
        logic                 msb;
        if (sig_w >= SIG_MAX_W) begin
            mask = '1;
        end else begin
            mask = (SIG_MAX_W'(1) << sig_w) - SIG_MAX_W'(1);
        end
        msb = (sig_w == 0) ? 1'b0 : sig[sig_w-1];
        return ((sig << 1) ^ (msb ? poly : '0) ^ fold) & mask;
    endfunction

endpackage

// File: rtl/signature_misr_acc_if.sv
// ---------------------------------------------------------------------------
// signature_misr_acc_if
// Bundles the control/data/result signals of the signature accumulator.
//   start, n_samples   : run request and sample budget (master -> slave)
//   data_valid, data   : sample stream from the module under test
//   busy, done         : run status (done is a one-cycle pulse)
//   signature          : current MISR value
//   sample_count       : samples absorbed in the current/last run
// The master modport is the driver (checker/bench), slave is the accumulator.
// ---------------------------------------------------------------------------
interface signature_misr_acc_if #(
    parameter int WIDTH = 1373,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16
) ();

    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             data_valid;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] sample_count;

    modport master (
        output start, n_samples, data_valid, data,
        input  busy, done, signature, sample_count
    );

    modport slave (
        input  start, n_samples, data_valid, data,
        output busy, done, signature, sample_count
    );

endinterface

// File: rtl/signature_misr_acc_fold.sv
// ---------------------------------------------------------------------------
// misr_fold
// Combinational XOR fold of a WIDTH-bit vector into SIG_W bits. The input is
// zero-padded at the MSB end to a whole number of SIG_W slices and all slices
// are XORed together.
//   data_i : WIDTH-bit vector to fold
//   fold_o : SIG_W-bit folded result
// ---------------------------------------------------------------------------
module misr_fold #(
    parameter int WIDTH = 1373,
    parameter int SIG_W = 32
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [SIG_W-1:0] fold_o
);

    localparam int NSLICE = (WIDTH + SIG_W - 1) / SIG_W;

    logic [NSLICE*SIG_W-1:0] padded;

    // Padding is built by clearing first, so WIDTH being an exact multiple of
    // SIG_W needs no special case.
    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = data_i;
        fold_o             = '0;
        for (int s = 0; s < NSLICE; s++) begin
            fold_o = fold_o ^ padded[s*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/signature_misr_acc.sv
// ---------------------------------------------------------------------------
// signature_misr_acc
// Folds a wide output vector into a SIG_W-bit MISR signature over a
// programmed number of valid samples, so the checker can compare compact
// signatures instead of full-width outputs.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of signature_misr_acc_if
//           start/n_samples/data_valid/data in, busy/done/signature/
//           sample_count out (all outputs registered)
// SIG_W is limited to misr_pkg::SIG_MAX_W (64).
// ---------------------------------------------------------------------------
module signature_misr_acc
    import misr_pkg::*;
#(
    parameter int               WIDTH = 1373,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(CRC32_POLY),
    parameter logic [SIG_W-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    signature_misr_acc_if.slave  bus
);

    misr_state_e      state_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] nsamp_q;
    logic             busy_q;
    logic             done_q;
    logic [SIG_W-1:0] fold_w;

    misr_fold #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W)
    ) u_fold (
        .data_i (bus.data),
        .fold_o (fold_w)
    );

    // Candidate next signature/count if the current sample is absorbed.
    always_comb begin
        sig_d = SIG_W'(misr_step(SIG_MAX_W'(sig_q), SIG_MAX_W'(POLY),
                                 SIG_MAX_W'(fold_w), SIG_W));
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Controller. IDLE and DONE share start handling so a start in the DONE
    // cycle relaunches directly. A zero budget skips RUN entirely. The run
    // ends on the edge that absorbs the last sample, so cnt_q never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            nsamp_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        nsamp_q <= bus.n_samples;
                        sig_q   <= SEED;
                        cnt_q   <= '0;
                        if (bus.n_samples == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.data_valid) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == nsamp_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.signature    = sig_q;
    assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_signature_misr_acc.sv
// ---------------------------------------------------------------------------
// tb_signature_misr_acc
// Directed bench for signature_misr_acc. Three instances:
//   dutA : WIDTH=64,   SEED=0            (control-flow scenarios)
//   dutB : WIDTH=64,   SEED=32'h80000000 (feedback tap)
//   dutW : WIDTH=1373, SEED=0            (long random run vs. local model)
// ---------------------------------------------------------------------------
module tb_signature_misr_acc;

    localparam logic [31:0] POLY_C = 32'h04C11DB7;

    logic clk;
    logic rst_n;

    int vecCount;
    int failCount;

    signature_misr_acc_if #(.WIDTH(64),   .SIG_W(32), .CNT_W(16)) ifA ();
    signature_misr_acc_if #(.WIDTH(64),   .SIG_W(32), .CNT_W(16)) ifB ();
    signature_misr_acc_if #(.WIDTH(1373), .SIG_W(32), .CNT_W(16)) ifW ();

    signature_misr_acc #(
        .WIDTH (64), .SIG_W (32), .POLY (32'h04C11DB7), .SEED (32'h0), .CNT_W (16)
    ) dutA (
        .clk (clk), .rst_n (rst_n), .bus (ifA)
    );

    signature_misr_acc #(
        .WIDTH (64), .SIG_W (32), .POLY (32'h04C11DB7), .SEED (32'h8000_0000), .CNT_W (16)
    ) dutB (
        .clk (clk), .rst_n (rst_n), .bus (ifB)
    );

    signature_misr_acc #(
        .WIDTH (1373), .SIG_W (32), .POLY (32'h04C11DB7), .SEED (32'h0), .CNT_W (16)
    ) dutW (
        .clk (clk), .rst_n (rst_n), .bus (ifW)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs on dutA and returns 1 time unit after the
    // absorbing edge, where registered outputs are settled.
    task automatic applyStimulus(input logic st, input logic [15:0] n,
                                 input logic v, input logic [63:0] d);
        ifA.start      = st;
        ifA.n_samples  = n;
        ifA.data_valid = v;
        ifA.data       = d;
        @(posedge clk);
        #1;
    endtask

    // Independent reference: bit i of the sample goes to signature bit i%32.
    function automatic logic [31:0] refStep(input logic [31:0] s, input logic [1372:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 1373; i++) begin
            f[i % 32] = f[i % 32] ^ d[i];
        end
        return {s[30:0], 1'b0} ^ (s[31] ? POLY_C : 32'h0) ^ f;
    endfunction

    initial begin
        logic [31:0]   refSig;
        logic [1372:0] wd;

        vecCount  = 0;
        failCount = 0;

        ifA.start = 1'b0; ifA.n_samples = '0; ifA.data_valid = 1'b0; ifA.data = '0;
        ifB.start = 1'b0; ifB.n_samples = '0; ifB.data_valid = 1'b0; ifB.data = '0;
        ifW.start = 1'b0; ifW.n_samples = '0; ifW.data_valid = 1'b0; ifW.data = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",  ifA.busy, 0);
        checkOutput("rst_done",  ifA.done, 0);
        checkOutput("rst_sig",   ifA.signature, 0);
        checkOutput("rst_cnt",   ifA.sample_count, 0);
        checkOutput("rst_sigB",  ifB.signature, 64'h8000_0000);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_exit_done", ifA.done, 0);

        // Scenario 1: slices cancel -> fold 0
        applyStimulus(1, 1, 0, 0);
        checkOutput("s1_busy", ifA.busy, 1);
        applyStimulus(0, 0, 1, 64'h0000_0001_0000_0001);
        checkOutput("s1_sig",  ifA.signature, 0);
        checkOutput("s1_done", ifA.done, 1);
        checkOutput("s1_cnt",  ifA.sample_count, 1);
        checkOutput("s1_busy_end", ifA.busy, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s1_done_pulse", ifA.done, 0);

        // Scenario 2: data valid alongside start must not be absorbed
        applyStimulus(1, 2, 1, 64'h1);
        checkOutput("s2_busy0", ifA.busy, 1);
        checkOutput("s2_cnt0",  ifA.sample_count, 0);
        checkOutput("s2_sig0",  ifA.signature, 0);
        applyStimulus(0, 0, 1, 64'h1);
        checkOutput("s2_sig1",  ifA.signature, 32'h1);
        checkOutput("s2_busy1", ifA.busy, 1);
        checkOutput("s2_done1", ifA.done, 0);
        applyStimulus(0, 0, 1, 64'h1);
        checkOutput("s2_sig2",  ifA.signature, 32'h3);
        checkOutput("s2_done2", ifA.done, 1);
        checkOutput("s2_busy2", ifA.busy, 0);
        checkOutput("s2_cnt2",  ifA.sample_count, 2);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s2_hold_sig", ifA.signature, 32'h3);
        checkOutput("s2_hold_cnt", ifA.sample_count, 2);

        // Scenario 4: gaps hold state, start and n_samples changes in RUN ignored
        applyStimulus(1, 3, 0, 0);
        applyStimulus(0, 3, 1, 64'h1);
        checkOutput("s4_sig_a", ifA.signature, 32'h1);
        applyStimulus(0, 9, 0, 64'hFFFF);
        checkOutput("s4_gap_sig", ifA.signature, 32'h1);
        checkOutput("s4_gap_cnt", ifA.sample_count, 1);
        applyStimulus(1, 7, 0, 64'hFFFF);
        checkOutput("s4_start_ign_sig",  ifA.signature, 32'h1);
        checkOutput("s4_start_ign_busy", ifA.busy, 1);
        applyStimulus(0, 0, 1, 64'h1);
        checkOutput("s4_sig_b",  ifA.signature, 32'h3);
        checkOutput("s4_done_b", ifA.done, 0);
        applyStimulus(0, 0, 1, 64'h1);
        checkOutput("s4_sig_c",  ifA.signature, 32'h7);
        checkOutput("s4_done_c", ifA.done, 1);
        checkOutput("s4_cnt_c",  ifA.sample_count, 3);
        applyStimulus(0, 0, 0, 0);

        // Scenario 5: zero budget, then relaunch from the DONE cycle
        applyStimulus(1, 0, 0, 0);
        checkOutput("s5_done", ifA.done, 1);
        checkOutput("s5_sig",  ifA.signature, 0);
        checkOutput("s5_cnt",  ifA.sample_count, 0);
        checkOutput("s5_busy", ifA.busy, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("s5_relaunch_busy", ifA.busy, 1);
        checkOutput("s5_relaunch_done", ifA.done, 0);
        applyStimulus(0, 0, 1, 64'h0000_0002_0000_0007);
        checkOutput("s5_relaunch_sig",  ifA.signature, 32'h5);
        checkOutput("s5_relaunch_fin",  ifA.done, 1);
        applyStimulus(0, 0, 0, 0);

        // Scenario 6: asynchronous reset in the middle of a run
        applyStimulus(1, 4, 0, 0);
        applyStimulus(0, 0, 1, 64'h1);
        applyStimulus(0, 0, 1, 64'h1);
        checkOutput("s6_pre_sig", ifA.signature, 32'h3);
        rst_n = 1'b0;
        #2;
        checkOutput("s6_rst_sig",  ifA.signature, 0);
        checkOutput("s6_rst_busy", ifA.busy, 0);
        checkOutput("s6_rst_done", ifA.done, 0);
        checkOutput("s6_rst_cnt",  ifA.sample_count, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 64'h1);
            checkOutput("s6_no_done", ifA.done, 0);
            checkOutput("s6_idle_sig", ifA.signature, 0);
        end
        applyStimulus(0, 0, 0, 0);

        // Scenario 3: feedback tap from SEED=0x80000000
        ifB.start = 1'b1; ifB.n_samples = 16'd1;
        @(posedge clk); #1;
        ifB.start = 1'b0; ifB.data_valid = 1'b1; ifB.data = '0;
        @(posedge clk); #1;
        ifB.data_valid = 1'b0;
        checkOutput("s3_sig",  ifB.signature, 64'h04C1_1DB7);
        checkOutput("s3_done", ifB.done, 1);

        // Scenario 7: 1373-bit random samples against the local model
        ifW.start = 1'b1; ifW.n_samples = 16'd1000;
        @(posedge clk); #1;
        ifW.start = 1'b0;
        refSig = 32'h0;
        for (int j = 0; j < 1000; j++) begin
            for (int b = 0; b < 1373; b++) begin
                wd[b] = 1'($urandom_range(0, 1));
            end
            ifW.data       = wd;
            ifW.data_valid = 1'b1;
            refSig         = refStep(refSig, wd);
            @(posedge clk); #1;
            if ((j % 100) == 99) begin
                checkOutput("s7_sig", ifW.signature, refSig);
            end
        end
        ifW.data_valid = 1'b0;
        checkOutput("s7_done", ifW.done, 1);
        checkOutput("s7_cnt",  ifW.sample_count, 1000);
        checkOutput("s7_busy", ifW.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
